serdes_frame_scheduler: RTL and testbench
=========================================

Name: serdes_frame_scheduler

Overview:
- Sequences the secure SERDES encryptor datapath and shares it between two byte-level requesters (ch0, ch1).
- Arbitrates round-robin and accepts one {A,B} byte pair.
- Drives the encryptor's 1-cycle start pulse, then serialises both bytes MSB-first over DATA_W cycles.
- Waits for the encryptor's done, captures the parallel cipher, and returns it with a channel tag over a valid/ready response port.

Parameters:
- DATA_W, 8, bits per operand and per cipher word; the bit counter is $clog2(DATA_W)+1 wide.
- TIMEOUT_CYC, 32, maximum WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-channel request valid; bit i = channel i.
- req_ready  out  2  per-channel accept strobe.
- req_a  in  2*DATA_W  operand A; [DATA_W-1:0] is ch0, upper half is ch1.
- req_b  in  2*DATA_W  operand B, same packing as req_a.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_ch  out  1  channel the result belongs to.
- rsp_cipher  out  DATA_W  captured cipher word.
- rsp_err  out  1  result aborted by timeout.
- enc_start  out  1  start pulse to the encryptor.
- enc_a_bit  out  1  serial A bit to the encryptor.
- enc_b_bit  out  1  serial B bit to the encryptor.
- enc_cipher  in  DATA_W  parallel cipher from the encryptor.
- enc_done  in  1  encryptor completion pulse.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: one clock, asynchronous active-high reset named rst. All outputs are 0, state = IDLE, shift registers and cipher register cleared, last_grant = 1 (so ch0 wins first). Asserting rst mid-operation aborts immediately; no response is emitted for the in-flight request.
- FSM states: IDLE, START, SHIFT, WAIT, RESP.
- IDLE: if any req_valid bit is set, grant one channel:
  - Both valid: grant the channel != last_grant.
  - Otherwise grant the single valid channel.
  - req_ready[g] is combinational, high only in IDLE and only for the granted valid channel.
  - On the handshake: capture req_a/req_b slices into a_sh/b_sh, latch ch = g, update last_grant = g, go to START.
  - req_ready is never high for both channels in the same cycle.
- START: enc_start = 1 for exactly one cycle; enc_a_bit/enc_b_bit = 0; bit counter loaded with DATA_W; go to SHIFT.
- SHIFT: enc_a_bit = a_sh[MSB], enc_b_bit = b_sh[MSB] (registered outputs). Shift left each cycle and decrement the counter. After exactly DATA_W cycles, go to WAIT.
- WAIT: on enc_done = 1, capture enc_cipher into rsp_cipher, set rsp_err = 0, go to RESP. enc_done is ignored in every other state, including the last SHIFT cycle.
- RESP: rsp_valid = 1, and rsp_ch/rsp_cipher/rsp_err are held stable until rsp_ready = 1. The cycle after the handshake, state is IDLE and rsp_valid = 0.
- New requests are never accepted in RESP. There is a one-cycle IDLE bubble minimum between jobs.
- Latency (accept = cycle 0, done asserted at the first WAIT cycle):
  - start at cycle 1;
  - bits at cycles 2..DATA_W+1;
  - WAIT at cycle DATA_W+2;
  - rsp_valid at cycle DATA_W+3.
- req_valid dropping while not granted: legal; no state change.
- Request data is sampled only at the handshake.

Optional Feature:
- Macro: SERDES_SCHED_TIMEOUT_EN.
- Defined: a WAIT-cycle counter runs. If TIMEOUT_CYC WAIT cycles pass without enc_done, go to RESP with rsp_err = 1 and rsp_cipher = 0. The counter clears on entering WAIT.
- Undefined: WAIT lasts indefinitely; rsp_err is tied to 0 and no counter is synthesised.

Decomposition:
- Package serdes_sched_pkg holds:
  - state encoding constants (IDLE=0, START=1, SHIFT=2, WAIT=3, RESP=4, 3-bit);
  - N_CH = 2;
  - default DATA_W and TIMEOUT_CYC.
- Sub-module serdes_rr_arbiter: 2-way round-robin. Inputs: req[1:0], last_grant, enable. Outputs: grant one-hot, grant_idx. Purely combinational; last_grant is held in the parent.

Test Plan:
- ch0 only, A=8'h02, B=8'h03 -> req_ready[0] 1 cycle; enc_start 1 cycle; enc_a_bit = 0,0,0,0,0,0,1,0 and enc_b_bit = 0,0,0,0,0,0,1,1 over the next 8 cycles; enc_done returned at the first WAIT cycle with cipher 8'h5A -> rsp_valid at cycle 11, rsp_ch=0, rsp_cipher=8'h5A, rsp_err=0.
- Both channels valid continuously for 4 jobs -> grants in order ch0, ch1, ch0, ch1; rsp_ch matches each grant.
- rsp_ready held low for 5 cycles -> rsp_valid and rsp fields stable; no req_ready asserted; after ready, IDLE for 1 cycle before the next accept.
- enc_done pulsed during START and SHIFT -> ignored; the response occurs only after the later WAIT-state done.
- rst asserted during SHIFT bit 4 -> all outputs 0 immediately; after release, a new ch0 request completes normally and ch0 wins first.
- With SERDES_SCHED_TIMEOUT_EN and TIMEOUT_CYC=32, enc_done never asserted -> rsp_valid after 32 WAIT cycles, rsp_err=1, rsp_cipher=0.

Source files
------------

// File: rtl/serdes_sched_pkg.sv
// serdes_sched_pkg: shared constants and state encoding for the SERDES frame scheduler.
package serdes_sched_pkg;

   localparam int N_CH            = 2;
   localparam int DATA_W_DEF      = 8;
   localparam int TIMEOUT_CYC_DEF = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      SHIFT = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/serdes_rr_arbiter.sv
// serdes_rr_arbiter: combinational 2-way round-robin pick; the last winner is held by the caller.
module serdes_rr_arbiter
   import serdes_sched_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  logic            last_grant,
   input  logic            enable,
   output logic [N_CH-1:0] grant,
   output logic            grant_idx
);

   // On contention the channel that did not win last time goes next.
   always_comb begin
      grant     = 2'b00;
      grant_idx = 1'b0;
      if (enable) begin
         case (req)
            2'b01: begin
               grant     = 2'b01;
               grant_idx = 1'b0;
            end
            2'b10: begin
               grant     = 2'b10;
               grant_idx = 1'b1;
            end
            2'b11: begin
               grant     = last_grant ? 2'b01 : 2'b10;
               grant_idx = ~last_grant;
            end
            default: begin
               grant     = 2'b00;
               grant_idx = 1'b0;
            end
         endcase
      end else begin
         grant     = 2'b00;
         grant_idx = 1'b0;
      end
   end

endmodule

// File: rtl/serdes_frame_scheduler.sv
// serdes_frame_scheduler: shares the serial encryptor between two byte requesters.
// Optional WAIT-state timeout is enabled by defining SERDES_SCHED_TIMEOUT_EN.
module serdes_frame_scheduler
   import serdes_sched_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_ch,
   output logic [DATA_W-1:0]   rsp_cipher,
   output logic                rsp_err,
   output logic                enc_start,
   output logic                enc_a_bit,
   output logic                enc_b_bit,
   input  logic [DATA_W-1:0]   enc_cipher,
   input  logic                enc_done,
   output logic                busy
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                last_grant_r;
   logic                ch_r;
   logic [DATA_W-1:0]   a_sh_r;
   logic [DATA_W-1:0]   b_sh_r;
   logic [DATA_W-1:0]   cipher_r;
   logic [CNT_W-1:0]    bit_cnt_r;
   logic                enc_start_r;
   logic                enc_a_bit_r;
   logic                enc_b_bit_r;
   logic                rsp_valid_r;
   logic                busy_r;
   logic [N_CH-1:0]     grant_s;
   logic                grant_idx_s;
   logic                arb_en_s;
   logic                accept_s;
   logic                timeout_s;

   // Reset gates the grant so req_ready is low while rst is held.
   assign arb_en_s = (state_r == IDLE) && !rst;
   assign accept_s = |grant_s;

   serdes_rr_arbiter u_arb (
      .req        (req_valid),
      .last_grant (last_grant_r),
      .enable     (arb_en_s),
      .grant      (grant_s),
      .grant_idx  (grant_idx_s)
   );

`ifdef SERDES_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

   logic [TO_W-1:0] wait_cnt_r;
   logic            rsp_err_r;

   assign timeout_s = (state_r == WAIT) && !enc_done &&
                      (wait_cnt_r == TO_W'(TIMEOUT_CYC - 1));

   // Count WAIT cycles; held at zero outside WAIT so each entry starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_r <= {TO_W{1'b0}};
      end else if (state_r != WAIT) begin
         wait_cnt_r <= {TO_W{1'b0}};
      end else begin
         wait_cnt_r <= wait_cnt_r + TO_W'(1);
      end
   end

   // Error flag: cleared by a real completion, set by a timeout abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_err_r <= 1'b0;
      end else if ((state_r == WAIT) && enc_done) begin
         rsp_err_r <= 1'b0;
      end else if (timeout_s) begin
         rsp_err_r <= 1'b1;
      end else begin
         rsp_err_r <= rsp_err_r;
      end
   end

   assign rsp_err = rsp_err_r;
`else
   assign timeout_s = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = START;
            else          state_nxt_s = IDLE;
         end
         START: state_nxt_s = SHIFT;
         SHIFT: begin
            if (bit_cnt_r == CNT_W'(1)) state_nxt_s = WAIT;
            else                        state_nxt_s = SHIFT;
         end
         WAIT: begin
            if (enc_done || timeout_s) state_nxt_s = RESP;
            else                       state_nxt_s = WAIT;
         end
         RESP: begin
            if (rsp_ready) state_nxt_s = IDLE;
            else           state_nxt_s = RESP;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Request capture and round-robin history, updated only on the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_r         <= 1'b0;
         last_grant_r <= 1'b1;
      end else if (accept_s) begin
         ch_r         <= grant_idx_s;
         last_grant_r <= grant_idx_s;
      end else begin
         ch_r         <= ch_r;
         last_grant_r <= last_grant_r;
      end
   end

   // Operand shift registers: load on accept, shift out MSB-first while serialising.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_r <= {DATA_W{1'b0}};
         b_sh_r <= {DATA_W{1'b0}};
      end else if (accept_s) begin
         a_sh_r <= grant_idx_s ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
         b_sh_r <= grant_idx_s ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
      end else if (state_nxt_s == SHIFT) begin
         a_sh_r <= {a_sh_r[DATA_W-2:0], 1'b0};
         b_sh_r <= {b_sh_r[DATA_W-2:0], 1'b0};
      end else begin
         a_sh_r <= a_sh_r;
         b_sh_r <= b_sh_r;
      end
   end

   // Bit counter: loaded leaving START, counts down one per SHIFT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == START) begin
         bit_cnt_r <= CNT_W'(DATA_W);
      end else if (state_r == SHIFT) begin
         bit_cnt_r <= bit_cnt_r - CNT_W'(1);
      end else begin
         bit_cnt_r <= bit_cnt_r;
      end
   end

   // Cipher capture; a timeout abort reports an all-zero word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cipher_r <= {DATA_W{1'b0}};
      end else if ((state_r == WAIT) && enc_done) begin
         cipher_r <= enc_cipher;
      end else if (timeout_s) begin
         cipher_r <= {DATA_W{1'b0}};
      end else begin
         cipher_r <= cipher_r;
      end
   end

   // Outputs registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enc_start_r <= 1'b0;
         enc_a_bit_r <= 1'b0;
         enc_b_bit_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         enc_start_r <= (state_nxt_s == START);
         enc_a_bit_r <= (state_nxt_s == SHIFT) ? a_sh_r[DATA_W-1] : 1'b0;
         enc_b_bit_r <= (state_nxt_s == SHIFT) ? b_sh_r[DATA_W-1] : 1'b0;
         rsp_valid_r <= (state_nxt_s == RESP);
         busy_r      <= (state_nxt_s != IDLE);
      end
   end

   assign req_ready  = grant_s;
   assign enc_start  = enc_start_r;
   assign enc_a_bit  = enc_a_bit_r;
   assign enc_b_bit  = enc_b_bit_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_ch     = ch_r;
   assign rsp_cipher = cipher_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_serdes_frame_scheduler.sv
// tb_serdes_frame_scheduler: directed + randomized jobs against a transaction-level reference.
// Exercises the timeout path when SERDES_SCHED_TIMEOUT_EN is defined.
module tb_serdes_frame_scheduler;

   localparam int DW = 8;
   localparam int TO = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [2*DW-1:0] req_a;
   logic [2*DW-1:0] req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_ch;
   logic [DW-1:0]   rsp_cipher;
   logic            rsp_err;
   logic            enc_start;
   logic            enc_a_bit;
   logic            enc_b_bit;
   logic [DW-1:0]   enc_cipher;
   logic            enc_done;
   logic            busy;

   int tests = 0;
   int fails = 0;
   bit last_grant_m;

   serdes_frame_scheduler #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_ch     (rsp_ch),
      .rsp_cipher (rsp_cipher),
      .rsp_err    (rsp_err),
      .enc_start  (enc_start),
      .enc_a_bit  (enc_a_bit),
      .enc_b_bit  (enc_b_bit),
      .enc_cipher (enc_cipher),
      .enc_done   (enc_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Round-robin rule: contention goes to the channel that did not win last.
   function automatic int ref_grant(input logic [1:0] v, input bit last);
      if (v == 2'b11) return last ? 0 : 1;
      else if (v[0])  return 0;
      else            return 1;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_ready"}, req_ready, 0);
      check({tag, "_start"}, enc_start, 0);
      check({tag, "_abit"}, enc_a_bit, 0);
      check({tag, "_bbit"}, enc_b_bit, 0);
      check({tag, "_rvalid"}, rsp_valid, 0);
      check({tag, "_rch"}, rsp_ch, 0);
      check({tag, "_rciph"}, rsp_cipher, 0);
      check({tag, "_rerr"}, rsp_err, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // One full job; done_dly < 0 means the encryptor never answers.
   task automatic run_job(input logic [1:0] vld, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                          input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                          input logic [DW-1:0] cipher, input int done_dly, input int hold,
                          input bit spur);
      int            g;
      logic [DW-1:0] ea, eb, got_a, got_b, exp_c;
      logic          exp_err;
      got_a = '0;
      got_b = '0;
      g = ref_grant(vld, last_grant_m);
      ea = (g == 1) ? a1 : a0;
      eb = (g == 1) ? b1 : b0;
      req_valid = vld;
      req_a = {a1, a0};
      req_b = {b1, b0};
      #1;
      check("accept_ready", req_ready, 32'(1 << g));
      check("accept_idle", busy, 0);
      tick();
      last_grant_m = (g == 1);
      // scramble requester side: only handshake data may be used
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      req_valid = 2'($urandom);
      #1;
      check("start_pulse", enc_start, 1);
      check("start_abit", enc_a_bit, 0);
      check("start_ready", req_ready, 0);
      check("start_busy", busy, 1);
      if (spur) enc_done = 1'b1;
      tick();
      enc_done = 1'b0;
      for (int i = 0; i < DW; i++) begin
         got_a = {got_a[DW-2:0], enc_a_bit};
         got_b = {got_b[DW-2:0], enc_b_bit};
         check("shift_start", enc_start, 0);
         check("shift_rvalid", rsp_valid, 0);
         req_valid = 2'($urandom);
         #1;
         check("shift_ready", req_ready, 0);
         if (spur && (i == 3 || i == DW - 1)) enc_done = 1'b1;
         tick();
         enc_done = 1'b0;
      end
      check("ser_a", got_a, ea);
      check("ser_b", got_b, eb);
      check("wait_rvalid", rsp_valid, 0);
      check("wait_abit", enc_a_bit, 0);
      exp_c = cipher;
      exp_err = 1'b0;
      if (done_dly < 0) begin
`ifdef SERDES_SCHED_TIMEOUT_EN
         for (int i = 0; i < TO; i++) begin
            check("to_wait_rvalid", rsp_valid, 0);
            tick();
         end
         exp_c = '0;
         exp_err = 1'b1;
`else
         for (int i = 0; i < TO + 8; i++) begin
            check("hang_rvalid", rsp_valid, 0);
            check("hang_busy", busy, 1);
            tick();
         end
         rst = 1'b1;
         #1;
         check("hang_rst_busy", busy, 0);
         tick();
         rst = 1'b0;
         last_grant_m = 1'b1;
         return;
`endif
      end else begin
         for (int i = 0; i < done_dly; i++) begin
            check("dly_rvalid", rsp_valid, 0);
            tick();
         end
         enc_done = 1'b1;
         enc_cipher = cipher;
         tick();
         enc_done = 1'b0;
         enc_cipher = DW'($urandom);
      end
      check("rsp_valid", rsp_valid, 1);
      check("rsp_ch", rsp_ch, g);
      check("rsp_cipher", rsp_cipher, exp_c);
      check("rsp_err", rsp_err, exp_err);
      for (int i = 0; i < hold; i++) begin
         req_valid = 2'($urandom);
         #1;
         check("hold_ready", req_ready, 0);
         tick();
         check("hold_valid", rsp_valid, 1);
         check("hold_ch", rsp_ch, g);
         check("hold_cipher", rsp_cipher, exp_c);
         check("hold_err", rsp_err, exp_err);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("post_rvalid", rsp_valid, 0);
      check("post_idle", busy, 0);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 2'b11;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = 1'b0;
      enc_cipher = '0;
      enc_done   = 1'b0;
      last_grant_m = 1'b1;
      tick();
      #1;
      check_quiet("in_reset");
      tick();
      rst = 1'b0;
      req_valid = 2'b00;
      #1;
      check_quiet("after_reset");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("noreq_busy", busy, 0);
         check("noreq_ready", req_ready, 0);
      end

      // contention from reset: ch0, ch1, ch0, ch1
      for (int j = 0; j < 4; j++) begin
         check("rr_order", ref_grant(2'b11, last_grant_m), j % 2);
         run_job(2'b11, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                 DW'($urandom), 0, 0, 1'b0);
      end

      // directed reference job, response on the 11th cycle after accept
      run_job(2'b01, 8'h02, 8'hFF, 8'h03, 8'hFF, 8'h5A, 0, 0, 1'b0);

      // long response back-pressure with spurious done pulses
      run_job(2'b10, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
              DW'($urandom), 2, 5, 1'b1);

      for (int j = 0; j < 12; j++) begin
         run_job(2'($urandom_range(3, 1)), DW'($urandom), DW'($urandom), DW'($urandom),
                 DW'($urandom), DW'($urandom), int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)), 1'($urandom));
      end

      // reset in the middle of serialisation
      req_valid = 2'b10;
      req_a = 16'hFFFF;
      req_b = 16'hFFFF;
      #1;
      check("mid_ready", req_ready, 2'b10);
      tick();
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) tick();
      check("mid_abit_hi", enc_a_bit, 1);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_quiet("mid_rst");
      tick();
      rst = 1'b0;
      last_grant_m = 1'b1;
      check("post_rst_pick", ref_grant(2'b11, last_grant_m), 0);
      run_job(2'b11, 8'hC3, 8'h3C, 8'hA5, 8'h5A, 8'h96, 0, 1, 1'b0);

      // encryptor never answers
      run_job(2'b01, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
              DW'($urandom), -1, 2, 1'b0);
      run_job(2'b11, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
              DW'($urandom), 1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
